// File: rtl/arb_burst_agent.sv
// Requester-side agent for a 4-way round-robin arbiter: queues per-client burst
// commands, drives req, and plays the granted client's burst onto a shared bus.
module arb_burst_agent #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          cmd_valid,
  output logic [3:0]          cmd_ready,
  input  logic [4*LEN_W-1:0]  cmd_len,
  input  logic [4*DATA_W-1:0] cmd_base,
  output logic [3:0]          req,
  input  logic [3:0]          grant,
  output logic                bus_valid,
  input  logic                bus_ready,
  output logic [1:0]          bus_id,
  output logic [DATA_W-1:0]   bus_data,
  output logic                bus_last,
  output logic                busy,
  output logic                grant_err
);

  localparam int unsigned NCH   = 4;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_GAP} state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [LEN_W-1:0]   r_fifo_len  [NCH][FIFO_DEPTH];
  logic [DATA_W-1:0]  r_fifo_base [NCH][FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wptr [NCH];
  logic [PTR_W-1:0]   r_rptr [NCH];
  logic [CNT_W-1:0]   r_cnt  [NCH];
  logic [CNT_W-1:0]   w_cnt_nxt [NCH];

  logic [1:0]         r_owner;
  logic [LEN_W-1:0]   r_len;
  logic [DATA_W-1:0]  r_base;
  logic [LEN_W-1:0]   r_beat;
  logic [1:0]         w_owner_nxt;
  logic [LEN_W-1:0]   w_len_nxt;
  logic [DATA_W-1:0]  w_base_nxt;
  logic [LEN_W-1:0]   w_beat_nxt;

  logic [3:0]         r_cmd_ready;
  logic [3:0]         r_req;
  logic               r_bus_valid;
  logic [1:0]         r_bus_id;
  logic [DATA_W-1:0]  r_bus_data;
  logic               r_bus_last;
  logic               r_busy;
  logic               r_grant_err;

  logic [3:0]         w_push;
  logic [3:0]         w_pop;
  logic [3:0]         w_req_nxt;
  logic [1:0]         w_gnt_idx;
  logic               w_multi;
  logic               w_onehot;

  assign cmd_ready = r_cmd_ready;
  assign req       = r_req;
  assign bus_valid = r_bus_valid;
  assign bus_id    = r_bus_id;
  assign bus_data  = r_bus_data;
  assign bus_last  = r_bus_last;
  assign busy      = r_busy;
  assign grant_err = r_grant_err;

  // Grant decode: multi-hot detection and index of the (assumed single) set bit.
  assign w_multi  = (grant & (grant - 4'd1)) != 4'd0;
  assign w_onehot = (grant != 4'd0) && !w_multi;

  always_comb begin
    w_gnt_idx = 2'd0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) w_gnt_idx = 2'(i);
    end
  end

  // Readiness comes from the registered count only, so a pop never frees a slot in the same cycle.
  assign w_push = cmd_valid & r_cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and burst-context logic.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_len_nxt   = r_len;
    w_base_nxt  = r_base;
    w_beat_nxt  = r_beat;
    w_pop       = 4'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_onehot && ((grant & r_req) != 4'd0)) begin
          w_state_nxt        = ST_BURST;
          w_owner_nxt        = w_gnt_idx;
          w_pop[w_gnt_idx]   = 1'b1;
          w_len_nxt          = r_fifo_len[w_gnt_idx][r_rptr[w_gnt_idx]];
          w_base_nxt         = r_fifo_base[w_gnt_idx][r_rptr[w_gnt_idx]];
          w_beat_nxt         = '0;
        end
      end
      ST_BURST: begin
        if (bus_ready) begin
          if (r_beat == r_len) w_state_nxt = ST_GAP;
          else                 w_beat_nxt  = r_beat + LEN_W'(1);
        end
      end
      ST_GAP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next counts and request lines, so req can be registered without a combinational path.
  always_comb begin
    w_req_nxt = 4'd0;
    for (int i = 0; i < NCH; i++) begin
      w_cnt_nxt[i] = r_cnt[i] + CNT_W'(w_push[i]) - CNT_W'(w_pop[i]);
      w_req_nxt[i] = (w_cnt_nxt[i] != '0) &&
                     !((w_state_nxt != ST_IDLE) && (w_owner_nxt == 2'(i)));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (w_push[i]) begin
        r_fifo_len[i][r_wptr[i]]  <= cmd_len[i*LEN_W +: LEN_W];
        r_fifo_base[i][r_wptr[i]] <= cmd_base[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_owner     <= 2'd0;
      r_len       <= '0;
      r_base      <= '0;
      r_beat      <= '0;
      r_cmd_ready <= 4'b1111;
      r_req       <= 4'd0;
      r_bus_valid <= 1'b0;
      r_bus_id    <= 2'd0;
      r_bus_data  <= '0;
      r_bus_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_grant_err <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + PTR_W'(1);
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + PTR_W'(1);
        r_cnt[i]       <= w_cnt_nxt[i];
        r_cmd_ready[i] <= w_cnt_nxt[i] != CNT_W'(FIFO_DEPTH);
      end
      r_owner     <= w_owner_nxt;
      r_len       <= w_len_nxt;
      r_base      <= w_base_nxt;
      r_beat      <= w_beat_nxt;
      r_req       <= w_req_nxt;
      r_bus_valid <= w_state_nxt == ST_BURST;
      r_bus_id    <= w_owner_nxt;
      r_bus_data  <= (w_state_nxt == ST_BURST) ? (w_base_nxt + DATA_W'(w_beat_nxt)) : '0;
      r_bus_last  <= (w_state_nxt == ST_BURST) && (w_beat_nxt == w_len_nxt);
      r_busy      <= w_state_nxt != ST_IDLE;
      r_grant_err <= w_multi;
    end
  end

endmodule

// File: tb/tb_arb_burst_agent.sv
// Bench for arb_burst_agent: closed loop with a registered round-robin arbiter,
// directed scenarios plus random traffic scored against a command-queue model.
module tb_arb_burst_agent;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned DEPTH  = 2;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] base;
  } cmd_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [3:0]          cmd_valid;
  logic [3:0]          cmd_ready;
  logic [4*LEN_W-1:0]  cmd_len;
  logic [4*DATA_W-1:0] cmd_base;
  logic [3:0]          req;
  logic [3:0]          grant;
  logic                bus_valid;
  logic                bus_ready;
  logic [1:0]          bus_id;
  logic [DATA_W-1:0]   bus_data;
  logic                bus_last;
  logic                busy;
  logic                grant_err;

  logic                force_en;
  logic [3:0]          force_grant;
  logic [3:0]          arb_grant;
  logic [1:0]          arb_ptr;
  logic [3:0]          arb_g;
  logic [1:0]          arb_np;
  logic [1:0]          arb_idx;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  arb_burst_agent #(.DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .cmd_base(cmd_base), .req(req), .grant(grant),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_id(bus_id),
    .bus_data(bus_data), .bus_last(bus_last), .busy(busy), .grant_err(grant_err)
  );

  // Registered round-robin arbiter closing the req/grant loop.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_grant <= 4'd0;
      arb_ptr   <= 2'd0;
    end else begin
      arb_g  = 4'd0;
      arb_np = arb_ptr;
      for (int k = 0; k < 4; k++) begin
        arb_idx = arb_ptr + 2'(k);
        if (req[arb_idx] && arb_g == 4'd0) begin
          arb_g[arb_idx] = 1'b1;
          arb_np         = arb_idx + 2'd1;
        end
      end
      arb_grant <= arb_g;
      arb_ptr   <= arb_np;
    end
  end

  assign grant = force_en ? force_grant : arb_grant;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: per-channel command queues and the burst currently on the bus.
  cmd_t       mq [4][$];
  cmd_t       p_cmd [4];
  logic [3:0] p_cmd_valid;
  logic       p_bus_valid;
  logic       p_bus_ready;
  cmd_t       m_cur;
  int         m_beat;
  logic       m_in_burst = 1'b0;
  logic       m_gap;
  logic       m_busy;
  logic [1:0] m_owner;
  logic [3:0] m_req;
  logic [3:0] m_rdy;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      m_in_burst  = 1'b0;
      m_owner     = 2'd0;
      p_cmd_valid = 4'd0;
      p_bus_valid = 1'b0;
      p_bus_ready = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (p_cmd_valid[i] && mq[i].size() < DEPTH) mq[i].push_back(p_cmd[i]);
      m_gap = 1'b0;
      if (m_in_burst && p_bus_valid && p_bus_ready) begin
        if (m_beat == int'(m_cur.len)) begin
          m_in_burst = 1'b0;
          m_gap      = 1'b1;
        end else begin
          m_beat++;
        end
      end
      if (m_gap) begin
        chk("m_gap_valid", 32'(bus_valid), 32'd0);
      end else if (m_in_burst) begin
        chk("m_hold_valid", 32'(bus_valid), 32'd1);
      end else if (bus_valid) begin
        chk("m_burst_src", 32'(mq[bus_id].size() != 0), 32'd1);
        if (mq[bus_id].size() != 0) begin
          m_cur      = mq[bus_id].pop_front();
          m_owner    = bus_id;
          m_beat     = 0;
          m_in_burst = 1'b1;
        end
      end
      if (m_in_burst) begin
        chk("m_bus_id",   32'(bus_id),   32'(m_owner));
        chk("m_bus_data", 32'(bus_data), 32'(8'(m_cur.base + 8'(m_beat))));
        chk("m_bus_last", 32'(bus_last), 32'(m_beat == int'(m_cur.len)));
      end
      m_busy = m_in_burst || m_gap;
      chk("m_busy", 32'(busy), 32'(m_busy));
      for (int i = 0; i < 4; i++) begin
        m_req[i] = (mq[i].size() != 0) && !(m_busy && m_owner == 2'(i));
        m_rdy[i] = mq[i].size() < DEPTH;
      end
      chk("m_req",       32'(req),       32'(m_req));
      chk("m_cmd_ready", 32'(cmd_ready), 32'(m_rdy));
      p_cmd_valid = cmd_valid;
      for (int i = 0; i < 4; i++) p_cmd[i] = {cmd_len[i*LEN_W +: LEN_W], cmd_base[i*DATA_W +: DATA_W]};
      p_bus_valid = bus_valid;
      p_bus_ready = bus_ready;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int ch, input logic [LEN_W-1:0] len, input logic [DATA_W-1:0] base);
    cmd_valid[ch]               = 1'b1;
    cmd_len[ch*LEN_W +: LEN_W]  = len;
    cmd_base[ch*DATA_W +: DATA_W] = base;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    cmd_valid = 4'd0;
    bus_ready = 1'b1;
    while ((busy || req != 4'd0 || bus_valid) && n < 400) begin
      step();
      n++;
    end
    chk({tag, "_drain"}, 32'(n < 400), 32'd1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] exp_d [4];
    int cnt_id [4];
    int k, st, nacc, n;
    rst_n = 1'b0; cmd_valid = 4'd0; cmd_len = '0; cmd_base = '0;
    bus_ready = 1'b1; force_en = 1'b0; force_grant = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",       32'(req),       32'd0);
    chk("rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'hF);
    chk("rst_grant_err", 32'(grant_err), 32'd0);
    chk("rst_bus_data",  32'(bus_data),  32'd0);
    rst_n = 1'b1;
    step();

    // Single command on channel 2.
    set_cmd(2, 4'd2, 8'h10);
    step();
    cmd_valid = 4'd0;
    chk("t1_req",    32'(req),       32'b0100);
    chk("t1_idle0",  32'(bus_valid), 32'd0);
    step();
    chk("t1_idle1",  32'(bus_valid), 32'd0);
    for (int b = 0; b < 3; b++) begin
      step();
      chk("t1_valid", 32'(bus_valid), 32'd1);
      chk("t1_id",    32'(bus_id),    32'd2);
      chk("t1_data",  32'(bus_data),  32'(8'h10 + 8'(b)));
      chk("t1_last",  32'(bus_last),  32'(b == 2));
    end
    step();
    chk("t1_gap_valid", 32'(bus_valid), 32'd0);
    chk("t1_gap_busy",  32'(busy),      32'd1);
    chk("t1_gap_req",   32'(req),       32'd0);
    step();
    chk("t1_end_busy",  32'(busy),      32'd0);
    chk("t1_end_req",   32'(req),       32'd0);

    // Two channels requesting together.
    set_cmd(0, 4'd0, 8'h20);
    set_cmd(1, 4'd0, 8'h21);
    step();
    cmd_valid = 4'd0;
    for (int i = 0; i < 4; i++) cnt_id[i] = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus_valid && bus_ready) cnt_id[bus_id]++;
      step();
    end
    chk("t2_ch0_once", 32'(cnt_id[0]), 32'd1);
    chk("t2_ch1_once", 32'(cnt_id[1]), 32'd1);
    drain("t2");

    // Backpressure with data wrap.
    exp_d[0] = 8'hFE; exp_d[1] = 8'hFF; exp_d[2] = 8'h00; exp_d[3] = 8'h01;
    set_cmd(1, 4'd3, 8'hFE);
    step();
    cmd_valid = 4'd0;
    k = 0; st = 0; nacc = 0; n = 0;
    while (nacc < 4 && n < 40) begin
      bus_ready = 1'b1;
      if (bus_valid) begin
        chk("t3_data", 32'(bus_data), 32'(exp_d[k]));
        chk("t3_last", 32'(bus_last), 32'(k == 3));
        chk("t3_id",   32'(bus_id),   32'd1);
        if ((k == 1 || k == 2) && st < 3) begin
          bus_ready = 1'b0;
          st++;
        end else begin
          k++; st = 0; nacc++;
        end
      end
      step();
      n++;
    end
    chk("t3_beats", 32'(nacc), 32'd4);
    drain("t3");

    // Channel 3 queue fills while the arbiter withholds its grant.
    force_en = 1'b1; force_grant = 4'd0;
    set_cmd(3, 4'd1, 8'h30);
    step();
    chk("t4_ready_1", 32'(cmd_ready[3]), 32'd1);
    set_cmd(3, 4'd1, 8'h40);
    step();
    chk("t4_ready_2", 32'(cmd_ready[3]), 32'd0);
    set_cmd(3, 4'd1, 8'h50);
    step();
    chk("t4_ready_3", 32'(cmd_ready[3]), 32'd0);
    cmd_valid = 4'd0;
    force_en = 1'b0;
    n = 0;
    while (!bus_valid && n < 10) begin
      chk("t4_no_bypass", 32'(cmd_ready[3]), 32'd0);
      step();
      n++;
    end
    chk("t4_pop_seen",  32'(bus_valid),    32'd1);
    chk("t4_ready_pop", 32'(cmd_ready[3]), 32'd1);
    chk("t4_base",      32'(bus_data),     32'h30);
    drain("t4");

    // Multi-hot grant and stale grant.
    force_en = 1'b1; force_grant = 4'd0;
    set_cmd(0, 4'd0, 8'h80);
    set_cmd(1, 4'd0, 8'h90);
    step();
    cmd_valid = 4'd0;
    chk("t5_req", 32'(req), 32'b0011);
    force_grant = 4'b0011;
    step();
    chk("t5_err_pulse", 32'(grant_err), 32'd1);
    chk("t5_err_busy",  32'(busy),      32'd0);
    force_grant = 4'd0;
    step();
    chk("t5_err_clr",   32'(grant_err), 32'd0);
    chk("t5_no_burst",  32'(bus_valid), 32'd0);
    force_grant = 4'b1000;
    step();
    chk("t5_stale_err",  32'(grant_err), 32'd0);
    chk("t5_stale_busy", 32'(busy),      32'd0);
    force_grant = 4'd0;
    step();
    chk("t5_stale_idle", 32'(bus_valid), 32'd0);
    force_en = 1'b0;
    drain("t5");

    // Reset in the middle of a burst.
    set_cmd(2, 4'd5, 8'h70);
    step();
    cmd_valid = 4'd0;
    n = 0;
    while (!bus_valid && n < 10) begin
      step();
      n++;
    end
    chk("t6_started", 32'(bus_valid), 32'd1);
    set_cmd(0, 4'd0, 8'h33);
    step();
    cmd_valid = 4'd0;
    chk("t6_beat1",   32'(bus_data), 32'h71);
    chk("t6_req_pre", 32'(req),      32'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(bus_valid), 32'd0);
    chk("t6_async_req",   32'(req),       32'd0);
    chk("t6_async_busy",  32'(busy),      32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("t6_post_valid", 32'(bus_valid), 32'd0);
    chk("t6_post_req",   32'(req),       32'd0);
    chk("t6_post_ready", 32'(cmd_ready), 32'hF);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if ($urandom_range(0, 3) == 0)
          set_cmd(ch, ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2)),
                  8'($urandom_range(0, 255)));
        else
          cmd_valid[ch] = 1'b0;
      end
      bus_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain("rand");
    for (int i = 0; i < 4; i++) chk("rand_queue_empty", 32'(mq[i].size()), 32'd0);
    chk("rand_grant_err", 32'(grant_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_burst_agent.md
Name: arb_burst_agent

Overview:
- Requester-side companion to the team's 4-way round-robin arbiter. It queues burst commands from four local clients and drives the arbiter's req[3:0]. It consumes the arbiter's registered grant[3:0] and then emits the granted client's burst on one shared output bus.
- It sits between the client logic and the shared resource. The arbiter sits beside it, closing the req/grant loop.

Parameters:
- DATA_W, 8, width of the bus_data payload.
- LEN_W, 4, width of the burst length field; cmd_len encodes beats-1.
- FIFO_DEPTH, 2, per-channel command queue depth (power of two, >=2).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- cmd_valid  in  4  per-channel command valid.
- cmd_ready  out  4  per-channel command ready.
- cmd_len  in  4*LEN_W  per-channel burst length minus 1; channel i occupies slice [i*LEN_W +: LEN_W].
- cmd_base  in  4*DATA_W  per-channel first data value; channel i occupies slice [i*DATA_W +: DATA_W].
- req  out  4  request lines to the arbiter.
- grant  in  4  grant lines from the arbiter, expected one-hot or zero.
- bus_valid  out  1  burst beat valid.
- bus_ready  in  1  downstream accepts the beat.
- bus_id  out  2  owning channel index.
- bus_data  out  DATA_W  beat payload.
- bus_last  out  1  final beat of the burst.
- busy  out  1  FSM not in IDLE.
- grant_err  out  1  one-cycle pulse when grant has more than one bit set.

Behaviour:
- Reset (async, rst_n=0):
  - All FIFOs are emptied and the FSM goes to IDLE.
  - Outputs: req=0, bus_valid=0, bus_id=0, bus_data=0, bus_last=0, busy=0, grant_err=0, cmd_ready=4'b1111.
  - The bus drops immediately, even mid-burst. No partial-burst recovery.
- Command queues:
  - Each channel has a FIFO_DEPTH-entry FIFO of {len, base}.
  - cmd_ready[i] = FIFO i not full, computed from the count before any pop that cycle (no bypass).
  - A push occurs on cmd_valid[i]&cmd_ready[i].
  - A push and a pop on the same FIFO in the same cycle are both performed; the count is unchanged.
- req[i]:
  - req[i] = (FIFO i non-empty) AND NOT (busy AND owner==i).
  - Driven purely from flops, so it is glitch-free.
  - Latency: a command accepted at edge N gives req high after edge N. With the arbiter's registered grant, the grant is seen after edge N+1 and bus_valid rises after edge N+2.
- FSM states: IDLE, BURST, GAP.
- IDLE:
  - If grant is one-hot and (grant & req)!=0: latch owner = index of the grant bit, pop FIFO[owner] into len_r/base_r, set beat=0, go to BURST.
  - A one-hot grant to a channel whose req is low (stale grant from arbiter latency) is ignored; stay in IDLE.
  - A grant with more than one bit set: pulse grant_err for one cycle, take no grant, stay in IDLE.
  - A zero grant: stay in IDLE.
- BURST:
  - Outputs: bus_valid=1, bus_id=owner, bus_data=(base_r+beat) mod 2^DATA_W (beat zero-extended), bus_last=(beat==len_r).
  - On bus_valid&bus_ready: if bus_last, go to GAP; else beat=beat+1.
  - If bus_ready is low, all bus outputs hold stable.
  - A burst is len_r+1 beats, from 1 to 2^LEN_W beats.
- GAP:
  - One cycle with bus_valid=0, then go to IDLE.
  - The gap absorbs a grant issued from the pre-burst req state.
- grant is ignored in BURST and GAP, except that grant_err still pulses on a multi-hot grant in any state.
- The owner's req stays low during BURST and GAP. It is re-raised after the return to IDLE if the owner's FIFO is still non-empty.
- Other channels' req lines are unaffected by the burst.
- Pushes to any channel, including the owner, are allowed in every state.

Test Plan:
- Single command:
  - Stimulus: ch2 cmd_len=2, cmd_base=8'h10; arbiter loop closed; bus_ready=1.
  - Response: req=4'b0100 one cycle after accept; 3 beats with bus_id=2, bus_data 10,11,12; bus_last on the third beat; one GAP cycle; req returns to 0.
- Round-robin interplay:
  - Stimulus: ch0 and ch1 each push one len=0 command in the same cycle.
  - Response: two separate single-beat bursts; each bus_id appears exactly once; no overlap; a GAP cycle between them.
- Backpressure:
  - Stimulus: len=3, base=8'hFE; bus_ready low on beats 1 and 2 for 3 cycles each.
  - Response: outputs hold during stalls; data FE,FF,00,01 (wrap); bus_last only on 01.
- FIFO full:
  - Stimulus: push 3 commands to ch3 while it holds no grant.
  - Response: cmd_ready[3]=0 after 2 pushes; the third push is not accepted. After the first pop, cmd_ready[3] returns to 1 one cycle later (no same-cycle bypass).
- Bad grant:
  - Stimulus: drive grant=4'b0011 in IDLE with req=4'b0011; then drive grant=4'b1000 with req[3]=0.
  - Response: first case gives a one-cycle grant_err pulse, no burst, busy=0. Second case is ignored with no grant_err.
- Reset mid-burst:
  - Stimulus: assert rst_n=0 during beat 1 of a len=5 burst.
  - Response: bus_valid and req drop asynchronously; after release, cmd_ready=4'b1111 and no residual burst or req.
